// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, qualifies its lock output and
// holds the PLL-domain system reset until lock has been stable long enough.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES = 27,
  parameter int STABLE_CYCLES  = 2700,
  parameter int TIMEOUT_CYCLES = 27000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock_i,
  output logic       pll_rst_o,
  output logic       sys_rst_o,
  output logic       locked_o,
  output logic       timeout_o,
  output logic [7:0] relock_count_o
);

  localparam int MAX_PS  = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
  localparam int MAX_ALL = (MAX_PS > TIMEOUT_CYCLES) ? MAX_PS : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    PLL_RESET,
    WAIT_LOCK,
    STABILIZE,
    RUN
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          timeout_next;
  logic [7:0]    relock_next;
  logic          sync_q, lock_s;

  // LOCK comes straight from the PLL, so it is retimed before any decision uses it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync_q <= pll_lock_i;
      lock_s <= sync_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= PLL_RESET;
      cnt            <= '0;
      pll_rst_o      <= 1'b1;
      sys_rst_o      <= 1'b1;
      locked_o       <= 1'b0;
      timeout_o      <= 1'b0;
      relock_count_o <= 8'd0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      pll_rst_o      <= (state_next == PLL_RESET);
      sys_rst_o      <= (state_next != RUN);
      locked_o       <= (state_next == RUN);
      timeout_o      <= timeout_next;
      relock_count_o <= relock_next;
    end
  end

  // One counter serves all timed states; it is cleared on every state change
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    timeout_next = 1'b0;
    relock_next  = relock_count_o;
    case (state)
      PLL_RESET: begin
        if (cnt == PLL_RST_LAST) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_next = STABILIZE;
          cnt_next   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next   = PLL_RESET;
          cnt_next     = '0;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
          if (relock_count_o != 8'hFF) begin
            relock_next = relock_count_o + 8'd1;
          end
        end
      end
      default: begin
        state_next = PLL_RESET;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small parameters so every
// latency can be counted by hand in edges after reset release or lock change.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock_i = 1'b0;
  logic       pll_rst_o;
  logic       sys_rst_o;
  logic       locked_o;
  logic       timeout_o;
  logic [7:0] relock_count_o;

  int test_count = 0;
  int fail_count = 0;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(4),
    .STABLE_CYCLES (8),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_lock_i    (pll_lock_i),
    .pll_rst_o     (pll_rst_o),
    .sys_rst_o     (sys_rst_o),
    .locked_o      (locked_o),
    .timeout_o     (timeout_o),
    .relock_count_o(relock_count_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive lock ahead of the next edge, then sample 1 ns after it
  task automatic applyStimulus(input logic lock);
    pll_lock_i = lock;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_pll_rst"}, pll_rst_o, 1);
    checkOutput({tag, "_sys_rst"}, sys_rst_o, 1);
    checkOutput({tag, "_locked"}, locked_o, 0);
    checkOutput({tag, "_timeout"}, timeout_o, 0);
    checkOutput({tag, "_relock"}, relock_count_o, 0);
  endtask

  // Leaves rst released 1 ns after an edge; the next edge is edge 1
  task automatic do_reset();
    rst = 1'b1;
    pll_lock_i = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  // Lock first sampled at edge 11; release is expected 10 edges later
  task automatic bring_up(input string tag);
    for (int n = 1; n <= 21; n++) begin
      applyStimulus(n >= 11);
      if (n == 3) checkOutput({tag, "_pll_rst_edge3"}, pll_rst_o, 1);
      if (n == 4) checkOutput({tag, "_pll_rst_edge4"}, pll_rst_o, 0);
      if (n == 20) checkOutput({tag, "_sys_rst_edge20"}, sys_rst_o, 1);
    end
    checkOutput({tag, "_sys_rst_run"}, sys_rst_o, 0);
    checkOutput({tag, "_locked_run"}, locked_o, 1);
    checkOutput({tag, "_pll_rst_run"}, pll_rst_o, 0);
    checkOutput({tag, "_relock_run"}, relock_count_o, 0);
  endtask

  task automatic drop_and_relock(input bit detail);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    if (detail) checkOutput("drop_sys_rst_edge1", sys_rst_o, 0);
    applyStimulus(1'b0);
    if (detail) begin
      checkOutput("drop_sys_rst_edge2", sys_rst_o, 1);
      checkOutput("drop_locked_edge2", locked_o, 0);
    end
    for (int n = 1; n <= 11; n++) applyStimulus(1'b1);
    if (detail) checkOutput("relock_sys_rst", sys_rst_o, 0);
  endtask

  initial begin
    // Reset values while rst is held
    do_reset();
    check_reset_values("reset");

    // Nominal bring-up
    bring_up("nominal");

    // Three lock losses in RUN, then saturation of the relock counter
    for (int i = 0; i < 3; i++) drop_and_relock(1'b1);
    checkOutput("relock_count_3", relock_count_o, 3);
    for (int i = 3; i < 255; i++) drop_and_relock(1'b0);
    checkOutput("relock_count_255", relock_count_o, 255);
    for (int i = 255; i < 300; i++) drop_and_relock(1'b0);
    checkOutput("relock_count_sat", relock_count_o, 255);
    checkOutput("relock_sat_locked", locked_o, 1);

    // Asynchronous reset mid-RUN, off the clock edge
    #3;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    do_reset();
    bring_up("rebringup");

    // No lock at all: timeout every 24 edges, sys_rst_o never released
    do_reset();
    for (int n = 1; n <= 72; n++) begin
      applyStimulus(1'b0);
      checkOutput($sformatf("nolock_timeout_e%0d", n), timeout_o, (n % 24) == 0);
      checkOutput($sformatf("nolock_pll_rst_e%0d", n), pll_rst_o, (n % 24) <= 3);
      checkOutput($sformatf("nolock_sys_rst_e%0d", n), sys_rst_o, 1);
    end

    // Lock glitch during STABILIZE: high 5, low 3, high again at edge 19
    do_reset();
    for (int n = 1; n <= 30; n++) begin
      applyStimulus((n >= 11 && n <= 15) || n >= 19);
      checkOutput($sformatf("glitch_sys_rst_e%0d", n), sys_rst_o, n < 29);
      checkOutput($sformatf("glitch_timeout_e%0d", n), timeout_o, 0);
    end
    checkOutput("glitch_locked", locked_o, 1);
    checkOutput("glitch_relock", relock_count_o, 0);

    // lock_s rises exactly when the wait counter reaches its last value
    do_reset();
    for (int n = 1; n <= 32; n++) begin
      applyStimulus(n >= 22);
      if (n == 24) begin
        checkOutput("boundary_timeout", timeout_o, 0);
        checkOutput("boundary_pll_rst", pll_rst_o, 0);
        checkOutput("boundary_sys_rst", sys_rst_o, 1);
      end
      if (n == 25) checkOutput("boundary_timeout_next", timeout_o, 0);
    end
    checkOutput("boundary_sys_rst_run", sys_rst_o, 0);
    checkOutput("boundary_locked_run", locked_o, 1);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
